// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, reset/bubble constants and the
// fetch FSM state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction memory lookup plus the IF/ID register outputs.
interface fetch_stage_if;
  import cpu_pkg::*;

  // ifid_valid qualifies ifid_pc/ifid_instr in the cycle it is high. There is no
  // ready: back-pressure reaches fetch through stall_i, not through this bus.
  logic [XLEN-1:0] instr_addr;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ifid_pc;
  logic [XLEN-1:0] ifid_instr;
  logic            ifid_valid;

  modport master (
    output instr_addr, pc, ifid_pc, ifid_instr, ifid_valid,
    input  instr
  );

  modport slave (
    input  instr_addr, pc, ifid_pc, ifid_instr, ifid_valid,
    output instr
  );

endinterface

// File: rtl/perf_counter.sv
// Free-running 32-bit event counter: increments when en_i is high, wraps
// modulo 2^32, cleared asynchronously by rst_i.
module perf_counter
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [XLEN-1:0] cnt_o
);

  logic [XLEN-1:0] cnt_q;
  logic [XLEN-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, IDLE/RUN
// control FSM, and stall/flush event counters. Instruction memory is external.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [31:0]           branch_target_i,
  output logic [31:0]           instr_addr_o,
  input  logic [31:0]           instr_i,
  output logic [31:0]           pc_o,
  output logic [31:0]           ifid_pc_o,
  output logic [31:0]           ifid_instr_o,
  output logic                  ifid_valid_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
  output cpu_pkg::fetch_state_e state_dbg_o
);

  cpu_pkg::fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_en;
  logic        stall_inc;
  logic        flush_inc;

  // FSM: state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= cpu_pkg::IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      cpu_pkg::IDLE: if (start_i)  state_d = cpu_pkg::RUN;
      cpu_pkg::RUN:  if (!start_i) state_d = cpu_pkg::IDLE;
      default:                     state_d = cpu_pkg::IDLE;
    endcase
  end

  // FSM: outputs. Decoding state_q means the IDLE->RUN cycle still acts as IDLE.
  always_comb begin
    fetch_en = 1'b0;
    if (state_q == cpu_pkg::RUN) fetch_en = 1'b1;
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!fetch_en) begin
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end else if (flush_i) begin
      // Flush wins over a simultaneous stall; the wrong-path fetch becomes a bubble.
      pc_d         = branch_target_i & ~32'h3;
      ifid_pc_d    = pc_q;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
      flush_inc    = 1'b1;
    end else if (stall_i) begin
      stall_inc    = 1'b1;
    end else begin
      pc_d         = pc_q + 32'd4;
      ifid_pc_d    = pc_q;
      ifid_instr_d = instr_i;
      ifid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  perf_counter u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  perf_counter u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (flush_inc),
    .cnt_o (flush_cnt_o)
  );

  assign instr_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural fetch model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] btgt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  fetch_state_e state_dbg;

  fetch_stage_if bus ();

  // External instruction memory: fixed word at address 0, address-derived elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] addr);
    if (addr == 32'h0) return 32'h0050_0093;
    return {addr[29:0], 2'b11};
  endfunction

  assign bus.instr = imem(bus.instr_addr);

  fetch_stage dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .stall_i         (stall),
    .flush_i         (flush),
    .branch_target_i (btgt),
    .instr_addr_o    (bus.instr_addr),
    .instr_i         (bus.instr),
    .pc_o            (bus.pc),
    .ifid_pc_o       (bus.ifid_pc),
    .ifid_instr_o    (bus.ifid_instr),
    .ifid_valid_o    (bus.ifid_valid),
    .stall_cnt_o     (stall_cnt),
    .flush_cnt_o     (flush_cnt),
    .state_dbg_o     (state_dbg)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_stall, m_flush;
  logic        m_valid, m_run;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_ifid_pc <= 32'h0; m_ifid_instr <= NOP; m_valid <= 1'b0;
      m_stall <= 32'h0; m_flush <= 32'h0; m_run <= 1'b0;
    end else begin
      if (!m_run) begin
        m_ifid_instr <= NOP;
        m_valid      <= 1'b0;
      end else if (flush) begin
        m_ifid_pc    <= m_pc;
        m_ifid_instr <= NOP;
        m_valid      <= 1'b0;
        m_pc         <= {btgt[31:2], 2'b00};
        m_flush      <= m_flush + 32'd1;
      end else if (stall) begin
        m_stall      <= m_stall + 32'd1;
      end else begin
        m_ifid_pc    <= m_pc;
        m_ifid_instr <= imem(m_pc);
        m_valid      <= 1'b1;
        m_pc         <= m_pc + 32'd4;
      end
      m_run <= start;
    end
  end

  // ---------------- compare process ----------------
  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_pc",         bus.pc,                 m_pc);
      chk("model_instr_addr", bus.instr_addr,         m_pc);
      chk("model_ifid_pc",    bus.ifid_pc,            m_ifid_pc);
      chk("model_ifid_instr", bus.ifid_instr,         m_ifid_instr);
      chk("model_ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
      chk("model_stall_cnt",  stall_cnt,              m_stall);
      chk("model_flush_cnt",  flush_cnt,              m_flush);
      chk("model_state_run",  {31'b0, state_dbg == RUN}, {31'b0, m_run});
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic s, input logic st, input logic fl, input logic [31:0] bt);
    start = s; stall = st; flush = fl; btgt = bt;
    @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pc"},         bus.pc,                  32'h0);
    chk({tag, "_ifid_pc"},    bus.ifid_pc,             32'h0);
    chk({tag, "_ifid_instr"}, bus.ifid_instr,          NOP);
    chk({tag, "_ifid_valid"}, {31'b0, bus.ifid_valid}, 32'h0);
    chk({tag, "_stall_cnt"},  stall_cnt,               32'h0);
    chk({tag, "_flush_cnt"},  flush_cnt,               32'h0);
    chk({tag, "_state"},      {31'b0, state_dbg == RUN}, 32'h0);
  endtask

  initial begin
    start = 1'b0; stall = 1'b0; flush = 1'b0; btgt = 32'h0;
    #1 rst = 1'b1;
    #1 chk_reset_values("por");
    cmp_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Start: first cycle is the IDLE->RUN transition, fetch begins after it.
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("start_pc0",        bus.pc, 32'h0);
    chk("start_valid0",     {31'b0, bus.ifid_valid}, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fetch0_pc",        bus.pc, 32'h4);
    chk("fetch0_ifid_instr", bus.ifid_instr, 32'h0050_0093);
    chk("fetch0_ifid_pc",   bus.ifid_pc, 32'h0);
    chk("fetch0_valid",     {31'b0, bus.ifid_valid}, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fetch1_pc",        bus.pc, 32'h8);

    // Two stall cycles at PC 8.
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall1_pc",        bus.pc, 32'h8);
    chk("stall1_ifid_pc",   bus.ifid_pc, 32'h4);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall2_pc",        bus.pc, 32'h8);
    chk("stall2_ifid_pc",   bus.ifid_pc, 32'h4);
    chk("stall2_cnt",       stall_cnt, 32'h2);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("resume_pc",        bus.pc, 32'hC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pre_flush_pc",     bus.pc, 32'h10);

    // Flush to a misaligned target: low bits dropped.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    chk("flush_pc",         bus.pc, 32'h40);
    chk("flush_ifid_instr", bus.ifid_instr, NOP);
    chk("flush_valid",      {31'b0, bus.ifid_valid}, 32'h0);
    chk("flush_cnt1",       flush_cnt, 32'h1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("post_flush_pc",    bus.pc, 32'h44);
    chk("post_flush_ifid_pc", bus.ifid_pc, 32'h40);

    // Flush and stall together: redirect wins, stall not counted.
    cyc(1'b1, 1'b1, 1'b1, 32'h0000_0080);
    chk("fs_pc",            bus.pc, 32'h80);
    chk("fs_flush_cnt",     flush_cnt, 32'h2);
    chk("fs_stall_cnt",     stall_cnt, 32'h2);

    // Drop start: one more RUN cycle, then frozen with bubbles for 3 cycles.
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("stop_pc",          bus.pc, 32'h84);
    cyc(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0);
    chk("idle_pc",          bus.pc, 32'h84);
    chk("idle_instr",       bus.ifid_instr, NOP);
    chk("idle_valid",       {31'b0, bus.ifid_valid}, 32'h0);
    chk("idle_stall_cnt",   stall_cnt, 32'h2);
    chk("idle_flush_cnt",   flush_cnt, 32'h2);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("restart_pc",       bus.pc, 32'h84);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("restart_fetch_pc", bus.pc, 32'h88);

    // PC wraps from the top of the address space.
    cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_top_pc",      bus.pc, 32'hFFFF_FFFC);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_pc",          bus.pc, 32'h0);
    chk("wrap_ifid_pc",     bus.ifid_pc, 32'hFFFF_FFFC);

    // Async reset mid-cycle at PC 0x40 while a flush and stall are pending.
    cyc(1'b1, 1'b0, 1'b1, 32'h0000_0043);
    chk("pre_rst_pc",       bus.pc, 32'h40);
    start = 1'b1; stall = 1'b1; flush = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_hold_pc",      bus.pc, 32'h40);
    stall = 1'b1; flush = 1'b1; btgt = 32'h0000_0100;
    rst = 1'b1;
    #1 chk_reset_values("async_rst");
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("after_rst_pc0",    bus.pc, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("after_rst_pc4",    bus.pc, 32'h4);
    chk("after_rst_instr",  bus.ifid_instr, 32'h0050_0093);

    // A few free-running cycles with scattered stalls for the model compare.
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, (i % 3) == 1, 1'b0, 32'h0);
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), giving the bubble instruction.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port start_i, input, 1 bit: run enable.
REQ-006 The block SHALL have port stall_i, input, 1 bit: load-use stall request from hazard detection.
REQ-007 The block SHALL have port flush_i, input, 1 bit: taken-branch flush from the ID stage.
REQ-008 The block SHALL have port branch_target_i, input, 32 bits: redirect address, valid when flush_i=1.
REQ-009 The block SHALL have port instr_addr_o, output, 32 bits: instruction memory byte address, equal to pc_o.
REQ-010 The block SHALL have port instr_i, input, 32 bits: instruction word returned combinationally for instr_addr_o.
REQ-011 The block SHALL have port pc_o, output, 32 bits: current fetch PC.
REQ-012 The block SHALL have port ifid_pc_o, output, 32 bits: IF/ID register PC.
REQ-013 The block SHALL have port ifid_instr_o, output, 32 bits: IF/ID register instruction.
REQ-014 The block SHALL have port ifid_valid_o, output, 1 bit: high when IF/ID holds a real fetched instruction.
REQ-015 The block SHALL have port stall_cnt_o, output, 32 bits: count of stall cycles.
REQ-016 The block SHALL have port flush_cnt_o, output, 32 bits: count of flush cycles.

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and RUN; reset enters IDLE; IDLE->RUN when start_i=1; RUN->IDLE when start_i=0.
REQ-018 In IDLE, the block SHALL hold the PC, load NOP_INSTR into IF/ID with ifid_valid_o=0, and leave both counters unchanged.
REQ-019 In RUN, with flush_i=0 and stall_i=0, the block SHALL update PC <= PC+4 (mod 2^32) and IF/ID <= {pc_o, instr_i}, with valid=1.
REQ-020 In RUN, with flush_i=1, the block SHALL set PC <= {branch_target_i[31:2],2'b00}, set IF/ID <= {pc_o, NOP_INSTR} with valid=0, and increment flush_cnt_o.
REQ-021 In RUN, with stall_i=1 and flush_i=0, the block SHALL hold the PC and IF/ID unchanged and increment stall_cnt_o.
REQ-022 When flush_i=1 and stall_i=1 occur in the same cycle, flush SHALL take priority and stall_cnt_o SHALL NOT increment.
REQ-023 The IF/ID latency SHALL be one cycle: an instruction presented at instr_i in cycle n appears on ifid_instr_o in cycle n+1.
REQ-024 instr_addr_o SHALL be driven combinationally from the PC register.
REQ-025 PC wrap SHALL be modular: PC 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-026 Counters SHALL wrap modularly: 32'hFFFF_FFFF increments to 0.
REQ-027 In the cycle where the FSM moves IDLE->RUN, the block SHALL behave as IDLE; the first fetch SHALL occur in the next cycle.

Reset
REQ-028 Asserting rst_i SHALL immediately, without waiting for a clock edge, set: state=IDLE; pc_o=RESET_PC; ifid_pc_o=0; ifid_instr_o=NOP_INSTR; ifid_valid_o=0; stall_cnt_o=0; flush_cnt_o=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending flush target and any held stall state.
REQ-030 After rst_i deasserts, fetch SHALL restart from RESET_PC.

Structure
REQ-031 The shared package cpu_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0013, RESET_PC, and the fetch FSM state enum.
REQ-032 Stall and flush counting SHALL be implemented in one sub-module, perf_counter (32-bit, enable-driven increment, asynchronous clear), instantiated twice.
REQ-033 No memory SHALL reside inside the block; the instruction memory SHALL be external.

Verification
REQ-034 Reset, then start_i=1 with instr_i=32'h00500093: the bench SHALL see pc_o sequence 0,0,4,8 and ifid_instr_o=32'h00500093 with valid=1, one cycle after the first fetch at PC 0.
REQ-035 stall_i=1 for 2 cycles at pc_o=8: the bench SHALL see pc_o and IF/ID held for 2 cycles, stall_cnt_o=2, and resumption at PC 12.
REQ-036 flush_i=1 with branch_target_i=32'h0000_0043 at pc_o=16: the bench SHALL see next pc_o=32'h40, ifid_instr_o=32'h13 with valid=0, and flush_cnt_o=1.
REQ-037 flush_i=1 and stall_i=1 together: the bench SHALL see a redirect taken, flush_cnt_o increment, and stall_cnt_o unchanged.
REQ-038 rst_i pulsed asynchronously mid-cycle while pc_o=32'h40: the bench SHALL see outputs at reset values before the next edge.
REQ-039 start_i dropped for 3 cycles: the bench SHALL see PC frozen, NOP bubbles in IF/ID, and counters frozen.
